// File: rtl/csync_pkg.sv
// Shared constants and lock-state type for the composite-sync decoder.
// PAL and NTSC defaults are selected by the top-level NTSC parameter.
package csync_pkg;

  localparam int PAL_LINE_CYCLES      = 5184;
  localparam int PAL_BROAD_MIN        = 1620;
  localparam int PAL_LINES_PER_FRAME  = 625;
  localparam int PAL_FIELD2_LINE      = 313;

  localparam int NTSC_LINE_CYCLES     = 5148;
  localparam int NTSC_BROAD_MIN       = 1620;
  localparam int NTSC_LINES_PER_FRAME = 525;
  localparam int NTSC_FIELD2_LINE     = 263;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/csync_pulse_meter.sv
// Synchronises raw csync, detects its edges and measures each low pulse.
// fall_strobe follows the first low sample by two clocks; width is valid with rise_strobe.
module csync_pulse_meter
  import csync_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        csync,
  output logic        fall_strobe,
  output logic        rise_strobe,
  output logic [15:0] width
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser, edge register, strobes and saturating low-width counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      prev_r      <= 1'b1;
      fall_strobe <= 1'b0;
      rise_strobe <= 1'b0;
      width       <= 16'd0;
    end else begin
      sync1_r     <= csync;
      sync2_r     <= sync1_r;
      prev_r      <= sync2_r;
      fall_strobe <= prev_r & ~sync2_r;
      rise_strobe <= ~prev_r & sync2_r;
      if (prev_r && !sync2_r) begin
        width <= 16'd1;
      end else if (!prev_r && !sync2_r && (width != 16'hFFFF)) begin
        width <= width + 16'd1;
      end else begin
        width <= width;
      end
    end
  end

endmodule

// File: rtl/csync_decoder.sv
// Composite-sync decoder: line lock with flywheel coasting, broad-pulse vsync,
// field identification and line counting on top of csync_pulse_meter.
module csync_decoder
  import csync_pkg::*;
#(
  parameter bit NTSC            = 1'b0,
  parameter int LINE_CYCLES     = NTSC ? NTSC_LINE_CYCLES : PAL_LINE_CYCLES,
  parameter int LINE_TOL        = 200,
  parameter int BROAD_MIN       = NTSC ? NTSC_BROAD_MIN : PAL_BROAD_MIN,
  parameter int LOCK_LINES      = 8,
  parameter int MAX_MISSES      = 4,
  parameter int LINES_PER_FRAME = NTSC ? NTSC_LINES_PER_FRAME : PAL_LINES_PER_FRAME,
  parameter int FIELD2_LINE     = NTSC ? NTSC_FIELD2_LINE : PAL_FIELD2_LINE,
  parameter int VSYNC_HOLDOFF   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csync,
  output logic       hsync_pulse,
  output logic       vsync_pulse,
  output logic       field_id,
  output logic [9:0] line_number,
  output logic       locked
);

  // The deciding cycle is tick 0, so the registered loads are one ahead.
  localparam logic [15:0] WIN_LO     = 16'(LINE_CYCLES - LINE_TOL);
  localparam logic [15:0] WIN_HI     = 16'(LINE_CYCLES + LINE_TOL);
  localparam logic [15:0] COAST_AT   = 16'(LINE_CYCLES + LINE_TOL + 1);
  localparam logic [15:0] COAST_LOAD = 16'(LINE_TOL + 2);
  localparam logic [15:0] QUARTER    = 16'(LINE_CYCLES / 4);
  localparam logic [15:0] THREE_Q    = 16'((3 * LINE_CYCLES) / 4);
  localparam logic [15:0] BROAD_N    = 16'(BROAD_MIN);
  localparam logic [7:0]  LOCK_N     = 8'(LOCK_LINES);
  localparam logic [7:0]  MISS_N     = 8'(MAX_MISSES);
  localparam logic [7:0]  HOLD_N     = 8'(VSYNC_HOLDOFF);
  localparam logic [9:0]  LPF_N      = 10'(LINES_PER_FRAME);
  localparam logic [9:0]  F2_N       = 10'(FIELD2_LINE);

  logic        fall_strobe_s;
  logic        rise_strobe_s;
  logic [15:0] width_s;

  lock_state_t state_r;
  logic [15:0] timer_r;
  logic [15:0] phase_r;
  logic [7:0]  valid_count_r;
  logic [7:0]  miss_count_r;
  logic [7:0]  holdoff_r;

  logic in_window_s;
  logic accept_s;
  logic coast_s;
  logic hsync_fire_s;
  logic vsync_fire_s;
  logic lock_gain_s;
  logic lock_loss_s;
  logic field_s;

  csync_pulse_meter u_meter (
    .clk         (clk),
    .reset       (reset),
    .csync       (csync),
    .fall_strobe (fall_strobe_s),
    .rise_strobe (rise_strobe_s),
    .width       (width_s)
  );

  // Per-cycle decisions: edge acceptance, coasting, lock transitions, vsync.
  always_comb begin
    in_window_s  = (timer_r >= WIN_LO) && (timer_r <= WIN_HI);
    accept_s     = fall_strobe_s && in_window_s;
    coast_s      = (state_r == LOCKED) && (timer_r == COAST_AT);
    hsync_fire_s = accept_s || coast_s;
    lock_gain_s  = (state_r == UNLOCKED) && accept_s && ((valid_count_r + 8'd1) == LOCK_N);
    lock_loss_s  = coast_s && ((miss_count_r + 8'd1) == MISS_N);
    vsync_fire_s = rise_strobe_s && locked && (width_s >= BROAD_N) && (holdoff_r == 8'd0);
    field_s      = !((phase_r < QUARTER) || (phase_r > THREE_Q));
  end

  // Line timer and lock state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= UNLOCKED;
      locked        <= 1'b0;
      hsync_pulse   <= 1'b0;
      timer_r       <= 16'hFFFF;
      valid_count_r <= 8'd0;
      miss_count_r  <= 8'd0;
    end else begin
      hsync_pulse <= hsync_fire_s;
      if (((state_r == UNLOCKED) && fall_strobe_s) || accept_s) begin
        timer_r <= 16'd1;
      end else if (coast_s) begin
        timer_r <= COAST_LOAD;
      end else if (timer_r != 16'hFFFF) begin
        timer_r <= timer_r + 16'd1;
      end else begin
        timer_r <= timer_r;
      end
      case (state_r)
        UNLOCKED: begin
          miss_count_r <= 8'd0;
          if (lock_gain_s) begin
            state_r       <= LOCKED;
            locked        <= 1'b1;
            valid_count_r <= 8'd0;
          end else if (accept_s) begin
            valid_count_r <= valid_count_r + 8'd1;
          end else if (fall_strobe_s) begin
            valid_count_r <= 8'd0;
          end else begin
            valid_count_r <= valid_count_r;
          end
        end
        LOCKED: begin
          if (accept_s) begin
            miss_count_r <= 8'd0;
          end else if (lock_loss_s) begin
            state_r       <= UNLOCKED;
            locked        <= 1'b0;
            valid_count_r <= 8'd0;
            miss_count_r  <= 8'd0;
          end else if (coast_s) begin
            miss_count_r <= miss_count_r + 8'd1;
          end else begin
            miss_count_r <= miss_count_r;
          end
        end
        default: begin
          state_r <= UNLOCKED;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Pulse phase, vsync holdoff, field identification and line counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r     <= 16'd0;
      holdoff_r   <= 8'd0;
      vsync_pulse <= 1'b0;
      field_id    <= 1'b0;
      line_number <= 10'd0;
    end else begin
      vsync_pulse <= vsync_fire_s;
      if (fall_strobe_s) begin
        phase_r <= timer_r;
      end else begin
        phase_r <= phase_r;
      end
      if (vsync_fire_s) begin
        holdoff_r <= HOLD_N;
        field_id  <= field_s;
      end else if (hsync_fire_s && (holdoff_r != 8'd0)) begin
        holdoff_r <= holdoff_r - 8'd1;
      end else begin
        holdoff_r <= holdoff_r;
      end
      if (lock_loss_s) begin
        line_number <= 10'd0;
      end else if (vsync_fire_s) begin
        line_number <= field_s ? F2_N : 10'd1;
      end else if (hsync_fire_s && (line_number != 10'd0)) begin
        line_number <= (line_number == LPF_N) ? 10'd1 : line_number + 10'd1;
      end else begin
        line_number <= line_number;
      end
    end
  end

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder on a scaled-down line (512 clk) so whole frames fit.
// Expected pulse times are queued as stimulus is driven and checked when outputs appear.
module tb_csync_decoder;

  localparam int LC      = 512;
  localparam int TOL     = 20;
  localparam int BMIN    = 160;
  localparam int LPF     = 25;
  localparam int F2      = 13;
  localparam int W_SYNC  = 38;
  localparam int W_EQ    = 19;
  localparam int W_BROAD = 218;

  logic       clk = 1'b0;
  logic       reset;
  logic       csync;
  logic       hsync_pulse;
  logic       vsync_pulse;
  logic       field_id;
  logic [9:0] line_number;
  logic       locked;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int last_h     = 0;
  int lock_probe = -1;
  int hq[$];
  int vq[$];

  always #5 clk = ~clk;

  csync_decoder #(
    .LINE_CYCLES     (LC),
    .LINE_TOL        (TOL),
    .BROAD_MIN       (BMIN),
    .LOCK_LINES      (8),
    .MAX_MISSES      (4),
    .LINES_PER_FRAME (LPF),
    .FIELD2_LINE     (F2),
    .VSYNC_HOLDOFF   (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .csync       (csync),
    .hsync_pulse (hsync_pulse),
    .vsync_pulse (vsync_pulse),
    .field_id    (field_id),
    .line_number (line_number),
    .locked      (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int exp_locked, input int exp_line, input int exp_field);
    chk("locked", 32'(locked), exp_locked);
    chk("line_number", 32'(line_number), exp_line);
    if (exp_field >= 0) chk("field_id", 32'(field_id), exp_field);
  endtask

  // One clock: sample outputs at the falling edge, score pulses, then drive inputs.
  task automatic step(input logic c, input logic r);
    int e;
    @(negedge clk);
    cyc++;
    while (hq.size() > 0 && hq[0] < cyc) begin
      e = hq.pop_front();
      chk("hsync_missing", cyc, e);
    end
    while (vq.size() > 0 && vq[0] < cyc) begin
      e = vq.pop_front();
      chk("vsync_missing", cyc, e);
    end
    if (hsync_pulse === 1'b1) begin
      if (hq.size() > 0) e = hq.pop_front();
      else e = -1;
      chk("hsync_cycle", cyc, e);
      if (lock_probe >= 0) chk("locked_at_hsync", 32'(locked), lock_probe);
    end
    if (vsync_pulse === 1'b1) begin
      if (vq.size() > 0) e = vq.pop_front();
      else e = -1;
      chk("vsync_cycle", cyc, e);
    end
    csync = c;
    reset = r;
  endtask

  // One line: optional pulse at 0 (w0), optional pulse at half line (w1).
  // hmode 0 none, 1 real edge, 2 first coast, 3 later coast; vmode 1/2 = vsync from pulse 0/half.
  task automatic line(input int w0, input int w1, input int hmode, input int vmode,
                      input int rst_at);
    logic c;
    for (int i = 0; i < LC; i++) begin
      c = !((i < w0) || ((i >= LC / 2) && (i < LC / 2 + w1)));
      step(c, (i == rst_at));
      if (i == 0) begin
        case (hmode)
          1: begin last_h = cyc + 4;            hq.push_back(last_h); end
          2: begin last_h = last_h + LC + TOL + 1; hq.push_back(last_h); end
          3: begin last_h = last_h + LC;        hq.push_back(last_h); end
          default: ;
        endcase
        if (vmode == 1) vq.push_back(cyc + w0 + 4);
      end
      if ((i == LC / 2) && (vmode == 2)) vq.push_back(cyc + w1 + 4);
      if ((rst_at >= 0) && (i == rst_at + 1)) begin
        chk("rst_hsync", 32'(hsync_pulse), 0);
        chk("rst_vsync", 32'(vsync_pulse), 0);
        chk_state(0, 0, 0);
      end
    end
  endtask

  initial begin
    csync = 1'b1;
    reset = 1'b1;
    repeat (4) step(1'b1, 1'b1);
    chk("reset_hsync", 32'(hsync_pulse), 0);
    chk("reset_vsync", 32'(vsync_pulse), 0);
    chk_state(0, 0, 0);

    // acquisition: first edge has no reference, lock on the 8th accepted pulse
    line(W_SYNC, 0, 0, 0, -1);
    lock_probe = 0;
    repeat (7) line(W_SYNC, 0, 1, 0, -1);
    lock_probe = 1;
    line(W_SYNC, 0, 1, 0, -1);
    lock_probe = -1;
    line(W_SYNC, 0, 1, 0, -1);
    chk_state(1, 0, -1);

    // equalising half-line pulses must not produce extra hsyncs
    repeat (5) line(W_EQ, W_EQ, 1, 0, -1);
    chk_state(1, 0, -1);

    // field 1: broad pulses from line start; holdoff suppresses later broad pulses
    line(W_BROAD, W_BROAD, 1, 1, -1);
    chk_state(1, 1, 0);
    line(W_BROAD, W_BROAD, 1, 0, -1);
    chk_state(1, 2, 0);
    line(W_BROAD, 0, 1, 0, -1);
    repeat (6) line(W_SYNC, 0, 1, 0, -1);
    line(W_BROAD, 0, 1, 0, -1);
    chk_state(1, 10, 0);
    line(W_SYNC, 0, 1, 0, -1);

    // field 2: broad pulse at half-line phase, then frame wrap
    line(W_SYNC, W_BROAD, 1, 2, -1);
    chk_state(1, F2, 1);
    repeat (12) line(W_SYNC, 0, 1, 0, -1);
    chk_state(1, LPF, 1);
    line(W_SYNC, 0, 1, 0, -1);
    chk_state(1, 1, 1);

    // flywheel: three missing syncs are coasted without losing lock
    line(0, 0, 2, 0, -1);
    line(0, 0, 3, 0, -1);
    line(0, 0, 3, 0, -1);
    chk_state(1, 4, -1);
    line(W_SYNC, 0, 1, 0, -1);
    chk_state(1, 5, -1);

    // reset mid-line, then full re-acquisition
    line(W_SYNC, 0, 1, 0, 300);
    line(W_SYNC, 0, 0, 0, -1);
    lock_probe = 0;
    repeat (7) line(W_SYNC, 0, 1, 0, -1);
    lock_probe = 1;
    line(W_SYNC, 0, 1, 0, -1);
    lock_probe = -1;
    chk_state(1, 0, 0);

    // four missing syncs drop lock and clear the line counter
    line(W_BROAD, 0, 1, 1, -1);
    chk_state(1, 1, 0);
    line(0, 0, 2, 0, -1);
    repeat (2) line(0, 0, 3, 0, -1);
    chk_state(1, 4, -1);
    lock_probe = 0;
    line(0, 0, 3, 0, -1);
    lock_probe = -1;
    chk_state(0, 0, -1);
    line(W_SYNC, 0, 1, 0, -1);
    chk_state(0, 0, -1);

    repeat (20) step(1'b1, 1'b0);
    chk("hsync_queue_left", hq.size(), 0);
    chk("vsync_queue_left", vq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
